// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two result sources and the register file write port.
// Groups both source handshakes, the registered write port and the pending mask.
interface regfile_write_arbiter_if #(
  parameter int MEM_SIZE  = 32,
  parameter int WORD_SIZE = 32
);
  localparam int IW = $clog2(MEM_SIZE);

  logic                 a_valid;
  logic                 a_ready;
  logic [IW-1:0]        a_reg;
  logic [WORD_SIZE-1:0] a_data;

  logic                 b_valid;
  logic                 b_ready;
  logic [IW-1:0]        b_reg;
  logic [WORD_SIZE-1:0] b_data;

  logic                 rf_wr;
  logic [IW-1:0]        rf_wr_reg;
  logic [WORD_SIZE-1:0] rf_wr_data;
  logic [MEM_SIZE-1:0]  pending_mask;

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    input  a_ready, b_ready,
    input  rf_wr, rf_wr_reg, rf_wr_data,
    input  pending_mask
  );

  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    output a_ready, b_ready,
    output rf_wr, rf_wr_reg, rf_wr_data,
    output pending_mask
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-source register file write arbiter with one-entry buffers per source.
// Define ARB_FIXED_PRIO_EN to make port B win contention between different registers.
module regfile_write_arbiter #(
  parameter int MEM_SIZE  = 32,
  parameter int WORD_SIZE = 32
) (
  input logic                   clk,
  input logic                   rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(MEM_SIZE);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  logic                 buf_a_valid_q, buf_a_valid_d;
  logic [IW-1:0]        buf_a_reg_q, buf_a_reg_d;
  logic [WORD_SIZE-1:0] buf_a_data_q, buf_a_data_d;

  logic                 buf_b_valid_q, buf_b_valid_d;
  logic [IW-1:0]        buf_b_reg_q, buf_b_reg_d;
  logic [WORD_SIZE-1:0] buf_b_data_q, buf_b_data_d;

  port_e older_q, older_d;
`ifndef ARB_FIXED_PRIO_EN
  port_e rr_q, rr_d;
`endif

  logic                 rf_wr_q, rf_wr_d;
  logic [IW-1:0]        rf_wr_reg_q, rf_wr_reg_d;
  logic [WORD_SIZE-1:0] rf_wr_data_q, rf_wr_data_d;

  logic both;
  logic same_reg;
  logic gnt_a;
  logic gnt_b;
  logic acc_a;
  logic acc_b;
  logic load_a;
  logic load_b;
  logic [MEM_SIZE-1:0] pend;

  assign both     = buf_a_valid_q & buf_b_valid_q;
  assign same_reg = (buf_a_reg_q == buf_b_reg_q);

  // Pick one buffered write per cycle from buffer state only.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (1'b1)
      (buf_a_valid_q & ~buf_b_valid_q): gnt_a = 1'b1;
      (buf_b_valid_q & ~buf_a_valid_q): gnt_b = 1'b1;
      (both & same_reg): begin
        gnt_a = (older_q == PORT_A);
        gnt_b = (older_q == PORT_B);
      end
      (both & ~same_reg): begin
`ifdef ARB_FIXED_PRIO_EN
        gnt_b = 1'b1;
`else
        gnt_a = (rr_q == PORT_A);
        gnt_b = (rr_q == PORT_B);
`endif
      end
      default: ;
    endcase
  end

  assign bus.a_ready = ~buf_a_valid_q | gnt_a;
  assign bus.b_ready = ~buf_b_valid_q | gnt_b;

  assign acc_a  = bus.a_valid & bus.a_ready;
  assign acc_b  = bus.b_valid & bus.b_ready;
  assign load_a = acc_a & (bus.a_reg != '0);
  assign load_b = acc_b & (bus.b_reg != '0);

  // Buffer A: drain on grant, reload on accept (x0 writes vanish).
  always_comb begin
    buf_a_valid_d = buf_a_valid_q;
    buf_a_reg_d   = buf_a_reg_q;
    buf_a_data_d  = buf_a_data_q;
    if (gnt_a) buf_a_valid_d = 1'b0;
    if (load_a) begin
      buf_a_valid_d = 1'b1;
      buf_a_reg_d   = bus.a_reg;
      buf_a_data_d  = bus.a_data;
    end
  end

  // Buffer B: same drain/reload rule as A.
  always_comb begin
    buf_b_valid_d = buf_b_valid_q;
    buf_b_reg_d   = buf_b_reg_q;
    buf_b_data_d  = buf_b_data_q;
    if (gnt_b) buf_b_valid_d = 1'b0;
    if (load_b) begin
      buf_b_valid_d = 1'b1;
      buf_b_reg_d   = bus.b_reg;
      buf_b_data_d  = bus.b_data;
    end
  end

  // A freshly loaded entry is younger than whatever the other buffer holds.
  always_comb begin
    older_d = older_q;
    if (load_a & load_b) older_d = PORT_A;
    else if (load_a)     older_d = PORT_B;
    else if (load_b)     older_d = PORT_A;
  end

`ifndef ARB_FIXED_PRIO_EN
  // Under contention the pointer moves to the port that lost.
  always_comb begin
    rr_d = rr_q;
    if (both) rr_d = gnt_a ? PORT_B : PORT_A;
  end
`endif

  // Output stage: load the winner, otherwise drop the enable and hold.
  always_comb begin
    rf_wr_d      = gnt_a | gnt_b;
    rf_wr_reg_d  = rf_wr_reg_q;
    rf_wr_data_d = rf_wr_data_q;
    if (gnt_a) begin
      rf_wr_reg_d  = buf_a_reg_q;
      rf_wr_data_d = buf_a_data_q;
    end else if (gnt_b) begin
      rf_wr_reg_d  = buf_b_reg_q;
      rf_wr_data_d = buf_b_data_q;
    end
  end

  // Registers with a write still on its way to the register file.
  always_comb begin
    pend = '0;
    if (buf_a_valid_q) pend[buf_a_reg_q] = 1'b1;
    if (buf_b_valid_q) pend[buf_b_reg_q] = 1'b1;
    if (rf_wr_q)       pend[rf_wr_reg_q] = 1'b1;
    pend[0] = 1'b0;
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_a_valid_q <= 1'b0;
      buf_a_reg_q   <= '0;
      buf_a_data_q  <= '0;
      buf_b_valid_q <= 1'b0;
      buf_b_reg_q   <= '0;
      buf_b_data_q  <= '0;
      older_q       <= PORT_A;
`ifndef ARB_FIXED_PRIO_EN
      rr_q          <= PORT_A;
`endif
      rf_wr_q       <= 1'b0;
      rf_wr_reg_q   <= '0;
      rf_wr_data_q  <= '0;
    end else begin
      buf_a_valid_q <= buf_a_valid_d;
      buf_a_reg_q   <= buf_a_reg_d;
      buf_a_data_q  <= buf_a_data_d;
      buf_b_valid_q <= buf_b_valid_d;
      buf_b_reg_q   <= buf_b_reg_d;
      buf_b_data_q  <= buf_b_data_d;
      older_q       <= older_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q          <= rr_d;
`endif
      rf_wr_q       <= rf_wr_d;
      rf_wr_reg_q   <= rf_wr_reg_d;
      rf_wr_data_q  <= rf_wr_data_d;
    end
  end

  assign bus.rf_wr        = rf_wr_q;
  assign bus.rf_wr_reg    = rf_wr_reg_q;
  assign bus.rf_wr_data   = rf_wr_data_q;
  assign bus.pending_mask = pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus
// randomized traffic against a sequence-numbered reference model.
module tb_regfile_write_arbiter;
  localparam int MS = 32;
  localparam int WS = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] wq[$];

  regfile_write_arbiter_if #(.MEM_SIZE(MS), .WORD_SIZE(WS)) bus ();

  regfile_write_arbiter #(.MEM_SIZE(MS), .WORD_SIZE(WS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state: one entry per port with acceptance order.
  bit          mv[2];
  logic [4:0]  mreg[2];
  logic [31:0] mdata[2];
  int          mseq[2];
  int          seqc;
  int          mrr;
  bit          m_wr;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  task automatic tick();
    @(negedge clk);
    if (bus.rf_wr) wq.push_back({bus.rf_wr_reg, bus.rf_wr_data});
  endtask

  task automatic set_a(input bit v, input int r, input logic [31:0] d);
    bus.a_valid = v; bus.a_reg = r[4:0]; bus.a_data = d;
  endtask

  task automatic set_b(input bit v, input int r, input logic [31:0] d);
    bus.b_valid = v; bus.b_reg = r[4:0]; bus.b_data = d;
  endtask

  task automatic apply_reset();
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wq.delete();
  endtask

  task automatic test_reset();
    set_a(0, 0, 0);
    set_b(0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL reset_rf_wr got %b want 0", bus.rf_wr); end
    n_cmp++; if (bus.rf_wr_reg !== 5'd0) begin n_err++; $display("FAIL reset_reg got %0d want 0", bus.rf_wr_reg); end
    n_cmp++; if (bus.rf_wr_data !== 32'd0) begin n_err++; $display("FAIL reset_data got %h want 0", bus.rf_wr_data); end
    n_cmp++; if (bus.pending_mask !== 32'd0) begin n_err++; $display("FAIL reset_mask got %h want 0", bus.pending_mask); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_ready got %b want 1", bus.a_ready); end
    n_cmp++; if (bus.b_ready !== 1'b1) begin n_err++; $display("FAIL reset_b_ready got %b want 1", bus.b_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    set_a(1, 5, 32'hDEADBEEF);
    #1;
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", bus.a_ready); end
    tick();
    set_a(0, 0, 0);
    #1;
    n_cmp++; if (bus.pending_mask !== 32'h20) begin n_err++; $display("FAIL single_mask1 got %h want 20", bus.pending_mask); end
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL single_early got %b want 0", bus.rf_wr); end
    tick();
    n_cmp++; if (bus.rf_wr !== 1'b1) begin n_err++; $display("FAIL single_wr got %b want 1", bus.rf_wr); end
    n_cmp++; if (bus.rf_wr_reg !== 5'd5) begin n_err++; $display("FAIL single_reg got %0d want 5", bus.rf_wr_reg); end
    n_cmp++; if (bus.rf_wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got %h want deadbeef", bus.rf_wr_data); end
    n_cmp++; if (bus.pending_mask !== 32'h20) begin n_err++; $display("FAIL single_mask2 got %h want 20", bus.pending_mask); end
    tick();
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL single_done got %b want 0", bus.rf_wr); end
    n_cmp++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL single_mask3 got %h want 0", bus.pending_mask); end
  endtask

  task automatic test_x0();
    apply_reset();
    set_b(1, 0, 32'h1234);
    #1;
    n_cmp++; if (bus.b_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", bus.b_ready); end
    tick();
    set_b(0, 0, 0);
    #1;
    n_cmp++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL x0_mask got %h want 0", bus.pending_mask); end
    tick();
    tick();
    n_cmp++; if (wq.size() !== 0) begin n_err++; $display("FAIL x0_writes got %0d want 0", wq.size()); end
  endtask

  task automatic test_contention();
    int na;
    int nb;
    logic [36:0] exp_q[$];
    apply_reset();
    na = 0;
    nb = 0;
    for (int c = 0; c < 30; c++) begin
      set_a(na < 4, 1, 32'h11);
      set_b(nb < 4, 2, 32'h22);
      #1;
`ifdef ARB_FIXED_PRIO_EN
      if (c <= 3) begin
        n_cmp++; if (bus.b_ready !== 1'b1) begin n_err++; $display("FAIL cont_b_ready c%0d got %b want 1", c, bus.b_ready); end
      end
`else
      if (c >= 1 && c <= 6) begin
        n_cmp++; if (bus.a_ready === bus.b_ready) begin n_err++; $display("FAIL cont_alt c%0d got %b%b want opposite", c, bus.a_ready, bus.b_ready); end
      end
`endif
      if (bus.a_valid && bus.a_ready) na++;
      if (bus.b_valid && bus.b_ready) nb++;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_q.push_back(i < 4 ? {5'd2, 32'h22} : {5'd1, 32'h11});
`else
      exp_q.push_back(i % 2 == 0 ? {5'd1, 32'h11} : {5'd2, 32'h22});
`endif
    end
    n_cmp++; if (wq.size() !== 8) begin n_err++; $display("FAIL cont_count got %0d want 8", wq.size()); end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      n_cmp++; if (wq[i] !== exp_q[i]) begin n_err++; $display("FAIL cont_seq%0d got %h want %h", i, wq[i], exp_q[i]); end
    end
  endtask

  task automatic test_same_reg();
    logic [36:0] exp_q[$];
    apply_reset();
    set_a(1, 3, 32'h33); set_b(1, 4, 32'h44); tick();
    set_a(0, 0, 0); set_b(0, 0, 0); tick();
    tick(); tick();
    set_a(1, 7, 32'hAA); set_b(1, 8, 32'h88); tick();
    set_a(0, 0, 0); set_b(1, 7, 32'hBB);
    #1;
    n_cmp++; if (bus.b_ready !== 1'b1) begin n_err++; $display("FAIL same_b_ready got %b want 1", bus.b_ready); end
    n_cmp++; if (bus.pending_mask !== 32'h180) begin n_err++; $display("FAIL same_mask got %h want 180", bus.pending_mask); end
    tick();
    set_b(0, 0, 0);
    repeat (5) tick();
`ifdef ARB_FIXED_PRIO_EN
    exp_q = '{{5'd4, 32'h44}, {5'd3, 32'h33}, {5'd8, 32'h88}, {5'd7, 32'hAA}, {5'd7, 32'hBB}};
`else
    exp_q = '{{5'd3, 32'h33}, {5'd4, 32'h44}, {5'd8, 32'h88}, {5'd7, 32'hAA}, {5'd7, 32'hBB}};
`endif
    n_cmp++; if (wq.size() !== 5) begin n_err++; $display("FAIL same_count got %0d want 5", wq.size()); end
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      n_cmp++; if (wq[i] !== exp_q[i]) begin n_err++; $display("FAIL same_seq%0d got %h want %h", i, wq[i], exp_q[i]); end
    end
  endtask

  task automatic test_simul_same();
    apply_reset();
    set_a(1, 9, 32'hA9); set_b(1, 9, 32'hB9); tick();
    set_a(0, 0, 0); set_b(0, 0, 0);
    #1;
    n_cmp++; if (bus.pending_mask !== 32'h200) begin n_err++; $display("FAIL simul_mask got %h want 200", bus.pending_mask); end
    repeat (4) tick();
    n_cmp++; if (wq.size() !== 2) begin n_err++; $display("FAIL simul_count got %0d want 2", wq.size()); end
    if (wq.size() == 2) begin
      n_cmp++; if (wq[0] !== {5'd9, 32'hA9}) begin n_err++; $display("FAIL simul_first got %h want 09_a9", wq[0]); end
      n_cmp++; if (wq[1] !== {5'd9, 32'hB9}) begin n_err++; $display("FAIL simul_second got %h want 09_b9", wq[1]); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_a(1, 10, 32'h10); set_b(1, 11, 32'h11); tick();
    set_a(1, 12, 32'h12); set_b(0, 0, 0); tick();
    set_a(0, 0, 0);
    #1;
    n_cmp++; if (bus.rf_wr !== 1'b1) begin n_err++; $display("FAIL mid_pre_wr got %b want 1", bus.rf_wr); end
    n_cmp++; if (bus.pending_mask !== 32'h1C00) begin n_err++; $display("FAIL mid_pre_mask got %h want 1c00", bus.pending_mask); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (bus.rf_wr !== 1'b0) begin n_err++; $display("FAIL mid_wr got %b want 0", bus.rf_wr); end
    n_cmp++; if (bus.pending_mask !== 32'h0) begin n_err++; $display("FAIL mid_mask got %h want 0", bus.pending_mask); end
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL mid_a_ready got %b want 1", bus.a_ready); end
    n_cmp++; if (bus.b_ready !== 1'b1) begin n_err++; $display("FAIL mid_b_ready got %b want 1", bus.b_ready); end
    #10 rst = 1'b1;
    wq.delete();
    repeat (4) tick();
    n_cmp++; if (wq.size() !== 0) begin n_err++; $display("FAIL mid_stale got %0d want 0", wq.size()); end
  endtask

  function automatic int m_grant();
    if (mv[0] && !mv[1]) return 0;
    if (mv[1] && !mv[0]) return 1;
    if (!mv[0]) return -1;
    if (mreg[0] == mreg[1]) return (mseq[0] < mseq[1]) ? 0 : 1;
`ifdef ARB_FIXED_PRIO_EN
    return 1;
`else
    return mrr;
`endif
  endfunction

  task automatic test_random();
    int g;
    bit rdy[2];
    bit both;
    bit iv[2];
    logic [4:0] ir[2];
    logic [31:0] id[2];
    logic [31:0] pm;
    logic [31:0] last[8];
    logic [31:0] obs[8];
    apply_reset();
    mv = '{0, 0}; seqc = 0; mrr = 0; m_wr = 0;
    for (int r = 0; r < 8; r++) begin last[r] = 0; obs[r] = 0; end
    for (int c = 0; c < 400; c++) begin
      set_a(c < 380 && $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      set_b(c < 380 && $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      #1;
      g = m_grant();
      rdy[0] = !mv[0] || g == 0;
      rdy[1] = !mv[1] || g == 1;
      pm = 0;
      for (int p = 0; p < 2; p++) if (mv[p]) pm[mreg[p]] = 1'b1;
      if (m_wr) pm[m_wreg] = 1'b1;
      n_cmp++; if (bus.a_ready !== rdy[0]) begin n_err++; $display("FAIL rnd_a_ready c%0d got %b want %b", c, bus.a_ready, rdy[0]); end
      n_cmp++; if (bus.b_ready !== rdy[1]) begin n_err++; $display("FAIL rnd_b_ready c%0d got %b want %b", c, bus.b_ready, rdy[1]); end
      n_cmp++; if (bus.rf_wr !== m_wr) begin n_err++; $display("FAIL rnd_wr c%0d got %b want %b", c, bus.rf_wr, m_wr); end
      n_cmp++; if (bus.pending_mask !== pm) begin n_err++; $display("FAIL rnd_mask c%0d got %h want %h", c, bus.pending_mask, pm); end
      if (m_wr) begin
        n_cmp++; if ({bus.rf_wr_reg, bus.rf_wr_data} !== {m_wreg, m_wdata}) begin
          n_err++; $display("FAIL rnd_wdata c%0d got %h want %h", c, {bus.rf_wr_reg, bus.rf_wr_data}, {m_wreg, m_wdata});
        end
      end
      if (bus.rf_wr) obs[bus.rf_wr_reg[2:0]] = bus.rf_wr_data;
      iv[0] = bus.a_valid; ir[0] = bus.a_reg; id[0] = bus.a_data;
      iv[1] = bus.b_valid; ir[1] = bus.b_reg; id[1] = bus.b_data;
      both = mv[0] && mv[1];
      m_wr = (g >= 0);
      if (g >= 0) begin
        m_wreg = mreg[g];
        m_wdata = mdata[g];
        mv[g] = 0;
        if (both) mrr = 1 - g;
      end
      for (int p = 0; p < 2; p++) begin
        if (iv[p] && rdy[p] && ir[p] != 0) begin
          last[ir[p][2:0]] = id[p];
          mv[p] = 1; mreg[p] = ir[p]; mdata[p] = id[p];
          mseq[p] = seqc; seqc++;
        end
      end
      @(negedge clk);
    end
    for (int r = 1; r < 8; r++) begin
      n_cmp++; if (obs[r] !== last[r]) begin n_err++; $display("FAIL rnd_final r%0d got %h want %h", r, obs[r], last[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_contention();
    test_same_reg();
    test_simul_same();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback sources: port A (ALU result) and port B (load data). Each source has a one-entry holding buffer with a valid/ready handshake. One buffered write is granted per cycle, and the winner drives registered rf_wr/rf_wr_reg/rf_wr_data into the register file write port. A pending-register bitmask is exported for hazard/stall logic in the decode stage.

Parameters:
MEM_SIZE, 32, number of architectural registers; register index width is $clog2(MEM_SIZE).
WORD_SIZE, 32, data width in bits.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
a_valid  input  1  port A request valid.
a_ready  output  1  port A buffer can accept.
a_reg  input  $clog2(MEM_SIZE)  port A destination register.
a_data  input  WORD_SIZE  port A write data.
b_valid  input  1  port B request valid.
b_ready  output  1  port B buffer can accept.
b_reg  input  $clog2(MEM_SIZE)  port B destination register.
b_data  input  WORD_SIZE  port B write data.
rf_wr  output  1  write enable to register file (registered).
rf_wr_reg  output  $clog2(MEM_SIZE)  write address (registered).
rf_wr_data  output  WORD_SIZE  write data (registered).
pending_mask  output  MEM_SIZE  bit r = 1 while a write to register r is buffered or in the output stage.

Behaviour:
- Reset (rst=0, async): buffers invalid, rf_wr=0, rf_wr_reg=0, rf_wr_data=0, pending_mask=0, round-robin pointer -> A, age flag cleared. In-flight writes are discarded.
- Handshake: transfer when x_valid && x_ready at posedge. x_ready = !bufx_valid || bufx granted this cycle, so back-to-back writes sustain one per cycle per port.
- Register 0: a request with x_reg == 0 is accepted (ready rules unchanged). It is not buffered, never reaches rf_wr, and never sets pending_mask.
- Age tracking: when both buffers are valid, an older flag records which entry was accepted first. If both were accepted in the same cycle, A is treated as older.
- Arbitration, combinational from buffer state:
  - Exactly one buffer valid: grant it.
  - Both valid, same register: grant the older entry (write ordering preserved).
  - Both valid, different registers: round-robin. The pointer names the preferred port and flips to the other port after every grant made under contention.
- Output stage: on a grant, the next posedge loads rf_wr=1 with the granted reg/data and invalidates that buffer. With no grant, rf_wr=0 (reg/data hold their previous values).
- Latency: request accepted at edge N, earliest rf_wr=1 during cycle N+1..N+2. The register file commits on the negedge inside the rf_wr=1 cycle.
- pending_mask is the OR of decoded valid buffer registers and the output-stage register when rf_wr=1. It is combinational from flops and excludes register 0.
- Simultaneous grant and new acceptance on the same port: the buffer reloads with the new entry and stays valid. The new entry becomes younger than the other buffer.
- Throughput cap: 1 write/cycle total. With both ports streaming continuously, each port is ready every other cycle.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: the round-robin pointer is removed and port B (load) always wins contention between different registers. The same-register oldest-first rule still applies.
- Undefined: round-robin as specified above.

Test Plan:
- Single write: reset, then A writes reg 5 = 0xDEADBEEF once -> next cycle rf_wr=1, rf_wr_reg=5, rf_wr_data=0xDEADBEEF; pending_mask[5]=1 for 2 cycles, then 0.
- x0 drop: B writes reg 0 = 0x1234 -> b_ready=1, rf_wr stays 0, pending_mask stays 0.
- Contention, round-robin: A (reg 1, 0x11) and B (reg 2, 0x22) held valid for 4 transfers each -> rf_wr sequence alternates A,B,A,B...; each ready toggles high every other cycle. Under ARB_FIXED_PRIO_EN, all B writes come first.
- Same-register ordering: A writes reg 7 = 0xAA at cycle N, B writes reg 7 = 0xBB at cycle N+1 while A is still buffered, with the pointer favouring B -> 0xAA is written before 0xBB; final reg 7 = 0xBB.
- Simultaneous same-register: A and B both write reg 9 in the same cycle -> A's value is written first, B's second.
- Reset mid-operation: both buffers full and rf_wr=1, then drive rst=0 asynchronously between edges -> rf_wr, pending_mask and both buffers clear immediately; after release, a_ready=b_ready=1 and no stale write appears.
